// File: rtl/sd_pkg.sv
// Shared definitions for the signed-digit adder pipeline.
// Latency: n/a (types, constants and helper functions only).
// Backpressure: n/a.
// Contents: digit encodings {plus,minus}, accumulator FSM states,
// sd_digit() digit decode and sd_value() whole-vector value.
package sd_pkg;

  localparam logic [1:0] SD_POS  = 2'b10;
  localparam logic [1:0] SD_NEG  = 2'b01;
  localparam logic [1:0] SD_ZERO = 2'b00;

  typedef enum logic {
    ACC_IDLE = 1'b0,
    ACC_BUSY = 1'b1
  } acc_state_t;

  // (1,1) decodes as zero, same as (0,0).
  function automatic logic signed [2:0] sd_digit(input logic p, input logic m);
    logic signed [2:0] d;
    d = 3'sd0;
    if (p && !m) d = 3'sd1;
    else if (m && !p) d = -3'sd1;
    return d;
  endfunction

  // Value of a signed-digit vector; used by the bench as its reference.
  function automatic int sd_value(input logic [31:0] plus, input logic [31:0] minus,
                                  input int width);
    int v;
    v = 0;
    for (int i = 0; i < width; i++) begin
      if (plus[i] && !minus[i]) v = v + (1 << i);
      else if (minus[i] && !plus[i]) v = v - (1 << i);
    end
    return v;
  endfunction

endpackage

// File: rtl/sd_adder_stage.sv
// Carry-free signed-digit adder stage: r + cout*2^WIDTH = a + b + cin.
// Latency: combinational.
// Backpressure: none (pure function of inputs).
// Ports: i_a_*/i_b_* operand digits, i_cin {plus,minus} transfer in,
//        o_r_* result digits, o_cout {plus,minus} transfer out of the top digit.
module sd_adder_stage
  import sd_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] i_a_plus,
  input  logic [WIDTH-1:0] i_a_minus,
  input  logic [WIDTH-1:0] i_b_plus,
  input  logic [WIDTH-1:0] i_b_minus,
  input  logic [1:0]       i_cin,
  output logic [WIDTH-1:0] o_r_plus,
  output logic [WIDTH-1:0] o_r_minus,
  output logic [1:0]       o_cout
);

  logic signed [2:0] w_s [WIDTH];     // digit-pair sum, -2..2
  logic signed [2:0] w_t [WIDTH+1];   // transfer into digit i (w_t[0] = cin)
  logic signed [2:0] w_w [WIDTH];     // interim sum digit
  logic signed [2:0] w_r [WIDTH];
  logic [WIDTH-1:0]  w_lower_neg;     // sum of the next-lower position is negative

  always_comb begin
    w_t[0]      = sd_digit(i_cin[1], i_cin[0]);
    w_lower_neg = '0;
    o_r_plus    = '0;
    o_r_minus   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_s[i]     = sd_digit(i_a_plus[i], i_a_minus[i]) + sd_digit(i_b_plus[i], i_b_minus[i]);
      w_w[i]     = 3'sd0;
      w_t[i+1]   = 3'sd0;
    end
    // Digit 0 looks at the incoming transfer; higher digits at the pair below.
    w_lower_neg[0] = w_t[0][2];
    for (int i = 1; i < WIDTH; i++) begin
      w_lower_neg[i] = w_s[i-1][2];
    end
    // Choosing t/w from the lower sign keeps w_i + t_i inside {-1,0,1}:
    // a non-negative lower sum can only send t in {0,+1}, negative only {-1,0}.
    for (int i = 0; i < WIDTH; i++) begin
      case (w_s[i])
        3'sd2:  begin w_t[i+1] = 3'sd1;  w_w[i] = 3'sd0; end
        -3'sd2: begin w_t[i+1] = -3'sd1; w_w[i] = 3'sd0; end
        3'sd1: begin
          if (w_lower_neg[i]) begin w_t[i+1] = 3'sd0; w_w[i] = 3'sd1;  end
          else                begin w_t[i+1] = 3'sd1; w_w[i] = -3'sd1; end
        end
        -3'sd1: begin
          if (w_lower_neg[i]) begin w_t[i+1] = -3'sd1; w_w[i] = 3'sd1;  end
          else                begin w_t[i+1] = 3'sd0;  w_w[i] = -3'sd1; end
        end
        default: begin w_t[i+1] = 3'sd0; w_w[i] = 3'sd0; end
      endcase
    end
    for (int i = 0; i < WIDTH; i++) begin
      w_r[i]       = w_w[i] + w_t[i];
      o_r_plus[i]  = (w_r[i] == 3'sd1);
      o_r_minus[i] = (w_r[i] == -3'sd1);
    end
    if (w_t[WIDTH] == 3'sd1)       o_cout = SD_POS;
    else if (w_t[WIDTH] == -3'sd1) o_cout = SD_NEG;
    else                           o_cout = SD_ZERO;
  end

endmodule

// File: rtl/sd_three_operand_adder_pipe.sv
// Two-stage pipelined SD adder R = X + Y + (Z or accumulator) + cin.
// Latency: 2 cycles accept->out_valid; 1 token/cycle normal, 1 per 3 cycles in acc mode.
// Backpressure: valid/ready; out_ready stalls stage 2 then stage 1, acc tokens wait for an empty pipe.
// Ports: in_valid/in_ready, x/y/z plus-minus operands, cin, acc_mode, acc_clear;
//        out_valid/out_ready, results plus-minus, cout_a (stage 1), cout_b (stage 2).
module sd_three_operand_adder_pipe
  import sd_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x_plus,
  input  logic [WIDTH-1:0] x_minus,
  input  logic [WIDTH-1:0] y_plus,
  input  logic [WIDTH-1:0] y_minus,
  input  logic [WIDTH-1:0] z_plus,
  input  logic [WIDTH-1:0] z_minus,
  input  logic [1:0]       cin,
  input  logic             acc_mode,
  input  logic             acc_clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] results_plus,
  output logic [WIDTH-1:0] results_minus,
  output logic [1:0]       cout_a,
  output logic [1:0]       cout_b
);

  // Stage-1 register bank
  logic             r_v1;
  logic [WIDTH-1:0] r_s1_plus, r_s1_minus, r_z_plus, r_z_minus;
  logic [1:0]       r_cout_a1;
  logic             r_mode1;
  // Stage-2 (output) register bank
  logic             r_out_valid;
  logic [WIDTH-1:0] r_res_plus, r_res_minus;
  logic [1:0]       r_cout_a2, r_cout_b;
  logic             r_mode2;
  // Accumulator
  acc_state_t       r_state;
  logic [WIDTH-1:0] r_acc_plus, r_acc_minus;

  logic [WIDTH-1:0] w_s1_plus, w_s1_minus, w_s2_plus, w_s2_minus, w_z_plus, w_z_minus;
  logic [1:0]       w_s1_cout, w_s2_cout;
  logic             w_adv1, w_adv2, w_accept, w_out_hs;

  assign w_adv2   = ~r_out_valid | out_ready;
  assign w_adv1   = ~r_v1 | w_adv2;
  // An acc token must see the accumulator after the previous acc token has
  // retired, so it is only taken into an empty pipeline.
  assign in_ready = w_adv1 & (~acc_mode | (~r_v1 & ~r_out_valid));
  assign w_accept = in_valid & in_ready;
  assign w_out_hs = r_out_valid & out_ready;

  assign w_z_plus  = acc_mode ? r_acc_plus  : z_plus;
  assign w_z_minus = acc_mode ? r_acc_minus : z_minus;

  sd_adder_stage #(.WIDTH(WIDTH)) u_stage1 (
    .i_a_plus (x_plus),    .i_a_minus (x_minus),
    .i_b_plus (y_plus),    .i_b_minus (y_minus),
    .i_cin    (cin),
    .o_r_plus (w_s1_plus), .o_r_minus (w_s1_minus),
    .o_cout   (w_s1_cout)
  );

  sd_adder_stage #(.WIDTH(WIDTH)) u_stage2 (
    .i_a_plus (r_s1_plus), .i_a_minus (r_s1_minus),
    .i_b_plus (r_z_plus),  .i_b_minus (r_z_minus),
    .i_cin    (SD_ZERO),
    .o_r_plus (w_s2_plus), .o_r_minus (w_s2_minus),
    .o_cout   (w_s2_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1       <= 1'b0;
      r_s1_plus  <= '0;
      r_s1_minus <= '0;
      r_z_plus   <= '0;
      r_z_minus  <= '0;
      r_cout_a1  <= SD_ZERO;
      r_mode1    <= 1'b0;
    end else if (w_adv1) begin
      r_v1 <= w_accept;
      if (w_accept) begin
        r_s1_plus  <= w_s1_plus;
        r_s1_minus <= w_s1_minus;
        r_z_plus   <= w_z_plus;
        r_z_minus  <= w_z_minus;
        r_cout_a1  <= w_s1_cout;
        r_mode1    <= acc_mode;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_res_plus  <= '0;
      r_res_minus <= '0;
      r_cout_a2   <= SD_ZERO;
      r_cout_b    <= SD_ZERO;
      r_mode2     <= 1'b0;
    end else if (w_adv2) begin
      r_out_valid <= r_v1;
      if (r_v1) begin
        r_res_plus  <= w_s2_plus;
        r_res_minus <= w_s2_minus;
        r_cout_a2   <= r_cout_a1;
        r_cout_b    <= w_s2_cout;
        r_mode2     <= r_mode1;
      end
    end
  end

  // Accumulator FSM: BUSY while an acc token is in flight; its result is
  // written back (carries dropped) on the output handshake. Clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ACC_IDLE;
      r_acc_plus  <= '0;
      r_acc_minus <= '0;
    end else begin
      case (r_state)
        ACC_IDLE: if (w_accept && acc_mode) r_state <= ACC_BUSY;
        ACC_BUSY: begin
          if (w_out_hs && r_mode2) begin
            r_state     <= ACC_IDLE;
            r_acc_plus  <= r_res_plus;
            r_acc_minus <= r_res_minus;
          end
        end
        default: r_state <= ACC_IDLE;
      endcase
      if (acc_clear) begin
        r_acc_plus  <= '0;
        r_acc_minus <= '0;
      end
    end
  end

  assign out_valid     = r_out_valid;
  assign results_plus  = r_res_plus;
  assign results_minus = r_res_minus;
  assign cout_a        = r_cout_a2;
  assign cout_b        = r_cout_b;

endmodule

// File: tb/tb_sd_three_operand_adder_pipe.sv
// Scoreboard bench for sd_three_operand_adder_pipe: expected sums are queued at
// acceptance and popped by an independent output monitor.
module tb_sd_three_operand_adder_pipe;
  import sd_pkg::*;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [W-1:0] x_plus, x_minus, y_plus, y_minus, z_plus, z_minus;
  logic [1:0]   cin;
  logic         acc_mode, acc_clear;
  logic         out_valid, out_ready;
  logic [W-1:0] results_plus, results_minus;
  logic [1:0]   cout_a, cout_b;

  typedef struct {
    int exp;
    bit acc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   acc_model = 0;   // value the accumulator holds right now
  int   acc_next  = 0;   // value it will hold after the coming edge
  bit   rand_en   = 1'b0;

  sd_three_operand_adder_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .x_plus(x_plus), .x_minus(x_minus),
    .y_plus(y_plus), .y_minus(y_minus),
    .z_plus(z_plus), .z_minus(z_minus),
    .cin(cin), .acc_mode(acc_mode), .acc_clear(acc_clear),
    .out_valid(out_valid), .out_ready(out_ready),
    .results_plus(results_plus), .results_minus(results_minus),
    .cout_a(cout_a), .cout_b(cout_b)
  );

  always #5 clk = ~clk;

  function automatic int v5(input logic [W-1:0] p, input logic [W-1:0] m);
    return sd_value(32'(p), 32'(m), W);
  endfunction

  function automatic int vc(input logic [1:0] c);
    return sd_value(32'(c[1]), 32'(c[0]), 1);
  endfunction

  function automatic int total_out();
    return v5(results_plus, results_minus) + (vc(cout_a) + vc(cout_b)) * (1 << W);
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Every cycle advance of the stimulus process goes through here, so it is
  // the only driver of out_ready / acc_clear.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_en) begin
      out_ready = ($urandom_range(0, 3) != 0);
      acc_clear = ($urandom_range(0, 39) == 0);
    end
  endtask

  task automatic set_token(input logic [W-1:0] xp, input logic [W-1:0] xm,
                           input logic [W-1:0] yp, input logic [W-1:0] ym,
                           input logic [W-1:0] zp, input logic [W-1:0] zm,
                           input logic [1:0] c, input logic mode);
    x_plus = xp; x_minus = xm; y_plus = yp; y_minus = ym;
    z_plus = zp; z_minus = zm; cin = c; acc_mode = mode;
  endtask

  task automatic rand_token(input logic mode);
    set_token(W'($urandom), W'($urandom), W'($urandom), W'($urandom),
              W'($urandom), W'($urandom), 2'($urandom), mode);
  endtask

  task automatic push_cur();
    exp_t e;
    e.acc = acc_mode;
    e.exp = v5(x_plus, x_minus) + v5(y_plus, y_minus) + vc(cin) +
            (acc_mode ? acc_model : v5(z_plus, z_minus));
    sb.push_back(e);
  endtask

  // Offer the currently driven token until accepted; returns 1 ns after the accepting edge.
  task automatic send();
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (in_ready) begin
        push_cur();
        done = 1'b1;
      end
      tick();
    end
    in_valid = 1'b0;
    if (!done) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 1000) begin
      tick();
      n++;
    end
    chk("drain_queue_size", sb.size(), 0);
  endtask

  // Output monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    acc_next = acc_model;
    if (rst) begin
      sb.delete();
      acc_next = 0;
    end else begin
      if (out_valid && out_ready) begin
        chk("no_11_result", int'(results_plus & results_minus), 0);
        chk("no_11_cout_a", int'(cout_a == 2'b11), 0);
        chk("no_11_cout_b", int'(cout_b == 2'b11), 0);
        if (sb.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("identity", total_out(), e.exp);
          // The accumulator keeps the digits only; their value is the sum
          // less whatever carries the adder chose to emit.
          if (e.acc) acc_next = v5(results_plus, results_minus);
        end
      end
      if (acc_clear) acc_next = 0;
    end
  end

  always @(posedge clk) acc_model <= acc_next;

  initial begin
    #900000;
    errors++;
    $display("FAIL watchdog: got still running, expected finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "time limit reached");
  end

  initial begin
    int  n_acc;
    int  stale;
    bit  took;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; acc_clear = 1'b0;
    set_token('0, '0, '0, '0, '0, '0, 2'b00, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_results", int'({results_plus, results_minus}), 0);
    chk("reset_couts", int'({cout_a, cout_b}), 0);
    chk("reset_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();

    // 1: 3 + 5, two-cycle latency
    out_ready = 1'b1;
    set_token(5'b00011, '0, 5'b00101, '0, '0, '0, 2'b00, 1'b0);
    send();
    @(negedge clk);
    chk("t1_latency_cycle1", int'(out_valid), 0);
    @(negedge clk);
    chk("t1_latency_cycle2", int'(out_valid), 1);
    chk("t1_value", total_out(), 8);
    tick();
    wait_empty();

    // 2: all digits -1, cin -1
    set_token('0, 5'b11111, '0, 5'b11111, '0, 5'b11111, 2'b01, 1'b0);
    send();
    @(negedge clk);
    @(negedge clk);
    chk("t2_value", total_out(), -94);
    tick();
    wait_empty();

    // 3: stall output, in_valid held high
    out_ready = 1'b0;
    n_acc = 0;
    rand_token(1'b0);
    in_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      took = in_ready;
      if (took) begin
        push_cur();
        n_acc++;
      end
      tick();
      if (took) rand_token(1'b0);
    end
    chk("t3_accepted_while_stalled", n_acc, 2);
    @(negedge clk);
    chk("t3_in_ready_low", int'(in_ready), 0);
    tick();
    out_ready = 1'b1;
    send();
    rand_token(1'b0);
    send();
    wait_empty();

    // 4: accumulate 3, 6, 9
    acc_clear = 1'b1;
    tick();
    acc_clear = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      set_token(5'b00001, '0, 5'b00010, '0, W'($urandom), W'($urandom), 2'b00, 1'b1);
      send();
      @(negedge clk);
      chk($sformatf("t4_in_ready_c1_k%0d", k), int'(in_ready), 0);
      @(negedge clk);
      chk($sformatf("t4_in_ready_c2_k%0d", k), int'(in_ready), 0);
      chk($sformatf("t4_out_valid_k%0d", k), int'(out_valid), 1);
      chk($sformatf("t4_acc_value_k%0d", k), v5(results_plus, results_minus), 3 * k);
      @(negedge clk);
      chk($sformatf("t4_in_ready_c3_k%0d", k), int'(in_ready), 1);
      tick();
    end

    // 5: clear in the same cycle as the accumulator load
    set_token('0, '0, '0, '0, '0, '0, 2'b00, 1'b1);
    send();
    tick();
    acc_clear = 1'b1;
    @(negedge clk);
    chk("t5_load_handshake", int'(out_valid & out_ready), 1);
    tick();
    acc_clear = 1'b0;
    set_token(5'b00001, '0, '0, '0, W'($urandom), W'($urandom), 2'b00, 1'b1);
    send();
    @(negedge clk);
    @(negedge clk);
    chk("t5_after_clear_value", v5(results_plus, results_minus), 1);
    tick();
    wait_empty();

    // 6: asynchronous reset with two tokens in flight
    out_ready = 1'b0;
    rand_token(1'b0);
    send();
    rand_token(1'b0);
    send();
    #3;
    rst = 1'b1;
    #1;
    chk("t6_out_valid_in_reset", int'(out_valid), 0);
    chk("t6_in_ready_in_reset", int'(in_ready), 1);
    tick();
    tick();
    #3;
    rst = 1'b0;
    out_ready = 1'b1;
    stale = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("t6_no_stale_token", stale, 0);
    tick();
    set_token(5'b00011, '0, '0, '0, W'($urandom), W'($urandom), 2'b00, 1'b1);
    send();
    wait_empty();

    // Random regression: random valid gaps, ready, clears and modes
    rand_en = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 4) == 0) tick();
      rand_token($urandom_range(0, 4) == 0);
      send();
    end
    rand_en = 1'b0;
    out_ready = 1'b1;
    acc_clear = 1'b0;
    wait_empty();
    repeat (4) tick();
    chk("final_queue_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
